// File: rtl/polvecp2bs_pkg.sv
// Shared constants and state encoding for the coefficient-to-bit-string packer.
// Word, slot and group geometry all derive from these values.
package polvecp2bs_pkg;

  localparam int WORD_W           = 64;
  localparam int ADDR_W           = 9;
  localparam int COEFF_W          = 10;
  localparam int SLOT_W           = 16;
  localparam int COEFFS_PER_WORD  = WORD_W / SLOT_W;
  localparam int PACKED_W         = COEFF_W * COEFFS_PER_WORD;
  localparam int READS_PER_GROUP  = 8;
  localparam int WRITES_PER_GROUP = 5;
  localparam int BUF_W            = READS_PER_GROUP * PACKED_W;
  localparam int SUB_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/polvecp2bs_coeff4_to_bits40.sv
// Extracts the low COEFF_W bits of each 16-bit slot and concatenates them,
// slot 0 landing in the least significant bits.
module coeff4_to_bits40
  import polvecp2bs_pkg::*;
(
  input  logic [WORD_W-1:0]   word,
  output logic [PACKED_W-1:0] bits40
);

  localparam int PAD_W = SLOT_W - COEFF_W;

  // Upper slot bits are deliberately dropped.
  logic [COEFFS_PER_WORD*PAD_W-1:0] unused_slot_bits;

  generate
    for (genvar gi = 0; gi < COEFFS_PER_WORD; gi++) begin : g_slot
      assign bits40[gi*COEFF_W +: COEFF_W]        = word[gi*SLOT_W +: COEFF_W];
      assign unused_slot_bits[gi*PAD_W +: PAD_W]  = word[gi*SLOT_W+COEFF_W +: PAD_W];
    end
  endgenerate

endmodule

// File: rtl/polvecp2bs.sv
// Packs 10-bit coefficients (four per 64-bit word) into a contiguous little-endian
// bit string: 8 reads fill a 320-bit buffer, then 5 words are written out.
module polvecp2bs
  import polvecp2bs_pkg::*;
#(
  parameter int NUM_IN_WORDS = 192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] read_address,
  input  logic [WORD_W-1:0] read_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [WORD_W-1:0] write_data,
  output logic              write_en,
  output logic              done
);

  localparam logic [SUB_W-1:0]  FILL_LAST_READ = SUB_W'(READS_PER_GROUP - 1);
  localparam logic [SUB_W-1:0]  FILL_LAST      = SUB_W'(READS_PER_GROUP);
  localparam logic [SUB_W-1:0]  WRITE_LAST     = SUB_W'(WRITES_PER_GROUP - 1);
  localparam logic [ADDR_W-1:0] LAST_READ_ADDR = ADDR_W'(NUM_IN_WORDS);

  state_t              state_reg, state_next;
  logic [SUB_W-1:0]    sub_cnt_reg, sub_cnt_next;
  logic [ADDR_W-1:0]   read_address_reg, read_address_next;
  logic [ADDR_W-1:0]   write_address_reg, write_address_next;
  logic [BUF_W-1:0]    buffer_reg, buffer_next;
  logic [PACKED_W-1:0] packed40;

  coeff4_to_bits40 u_pack (
    .word   (read_data),
    .bits40 (packed40)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= ST_IDLE;
      sub_cnt_reg       <= '0;
      read_address_reg  <= '0;
      write_address_reg <= '0;
    end else begin
      state_reg         <= state_next;
      sub_cnt_reg       <= sub_cnt_next;
      read_address_reg  <= read_address_next;
      write_address_reg <= write_address_next;
    end
  end

  // The data buffer carries no control meaning, so it is left unreset.
  always_ff @(posedge clk) begin
    buffer_reg <= buffer_next;
  end

  always_comb begin
    state_next         = state_reg;
    sub_cnt_next       = sub_cnt_reg;
    read_address_next  = read_address_reg;
    write_address_next = write_address_reg;
    buffer_next        = buffer_reg;
    write_en           = 1'b0;
    done               = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        done = (state_reg == ST_DONE);
        if (start) begin
          state_next         = ST_FILL;
          sub_cnt_next       = '0;
          read_address_next  = '0;
          write_address_next = '0;
        end
      end

      ST_FILL: begin
        // Reads issue on sub-cycles 0..7; data arrives one cycle later (1..8).
        if (sub_cnt_reg <= FILL_LAST_READ) begin
          read_address_next = read_address_reg + 1'b1;
        end
        if (sub_cnt_reg != '0) begin
          buffer_next = {packed40, buffer_reg[BUF_W-1:PACKED_W]};
        end
        if (sub_cnt_reg == FILL_LAST) begin
          state_next   = ST_WRITE;
          sub_cnt_next = '0;
        end else begin
          sub_cnt_next = sub_cnt_reg + 1'b1;
        end
      end

      ST_WRITE: begin
        write_en           = 1'b1;
        buffer_next        = {{WORD_W{1'b0}}, buffer_reg[BUF_W-1:WORD_W]};
        write_address_next = write_address_reg + 1'b1;
        if (sub_cnt_reg == WRITE_LAST) begin
          sub_cnt_next = '0;
          state_next   = (read_address_reg == LAST_READ_ADDR) ? ST_DONE : ST_FILL;
        end else begin
          sub_cnt_next = sub_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign read_address  = read_address_reg;
  assign write_address = write_address_reg;
  assign write_data    = buffer_reg[WORD_W-1:0];

endmodule

// File: tb/tb_polvecp2bs.sv
// Directed bench: synchronous RAM model feeds the packer, a scoreboard queue holds
// the expected bit-string words built from an independent bit-level model.
module tb_polvecp2bs;

  localparam int NWORDS  = 192;
  localparam int NWRITES = 120;
  localparam int RUN_CYC = 336;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  read_address;
  logic [63:0] read_data;
  logic [8:0]  write_address;
  logic [63:0] write_data;
  logic        write_en;
  logic        done;

  logic [63:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic [8:0]  addr;
  } wr_t;
  wr_t exp_q[$];

  polvecp2bs #(.NUM_IN_WORDS(NWORDS)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .read_address  (read_address),
    .read_data     (read_data),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) read_data <= mem[read_address];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit g of the output string is bit (g mod 10) of coefficient g/10.
  function automatic logic [63:0] model_word(input int w);
    logic [63:0] r;
    logic [63:0] src;
    int g, ci, sh;
    r = '0;
    for (int b = 0; b < 64; b++) begin
      g   = 64 * w + b;
      ci  = g / 10;
      src = mem[ci / 4];
      sh  = 16 * (ci % 4) + (g % 10);
      r[b] = src[sh];
    end
    return r;
  endfunction

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int w = 0; w < NWORDS; w++) begin
      case (mode)
        0: mem[w] = 64'h03FF_03FF_03FF_03FF;
        1: mem[w] = 64'hFC00_FC00_FC00_FC00;
        default: begin
          for (int j = 0; j < 4; j++) mem[w][16*j +: 16] = 16'((4 * w + j) % 1024);
        end
      endcase
    end
  endtask

  // Pulses start, checks every cycle of a full run, then the final DONE state.
  task automatic run_and_check(input string name, input bit poke_start);
    int writes;
    wr_t e;
    exp_q.delete();
    for (int w = 0; w < NWRITES; w++) begin
      e.data = model_word(w);
      e.addr = 9'(w);
      exp_q.push_back(e);
    end
    writes = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < RUN_CYC; n++) begin
      check({name, "_we_phase"}, 64'(write_en), 64'((n % 14) >= 9));
      check({name, "_done_low"}, 64'(done), 64'd0);
      check({name, "_rd_bound"}, 64'(read_address <= 9'd192), 64'd1);
      if (write_en) begin
        if (exp_q.size() == 0) begin
          check({name, "_extra_write"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check({name, "_wdata"}, write_data, e.data);
          check({name, "_waddr"}, 64'(write_address), 64'(e.addr));
          $display("%s write #%0d addr=%0d data=%h", name, writes, write_address, write_data);
        end
        writes++;
      end
      start = (poke_start && (n == 20 || n == 150)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_we_done"}, 64'(write_en), 64'd0);
    check({name, "_rd_final"}, 64'(read_address), 64'd192);
    check({name, "_wr_final"}, 64'(write_address), 64'd120);
    check({name, "_nwrites"}, 64'(writes), 64'(NWRITES));
    check({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check({name, "_done_hold"}, 64'(done), 64'd1);
    check({name, "_rd_hold"}, 64'(read_address), 64'd192);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    fill_mem(0);
    repeat (3) @(negedge clk);
    check("rst_we", 64'(write_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd", 64'(read_address), 64'd0);
    check("rst_wr", 64'(write_address), 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_we", 64'(write_en), 64'd0);
    check("idle_done", 64'(done), 64'd0);

    run_and_check("ones", 1'b0);

    fill_mem(1);
    run_and_check("masked", 1'b0);

    fill_mem(2);
    check("ramp_first_model", model_word(0), 64'h6014_0400_C020_0400);
    run_and_check("ramp_poke", 1'b1);
    run_and_check("ramp_again", 1'b0);

    // Abort in the first WRITE cycle of group 7.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (107) @(negedge clk);
    check("abort_pre_we", 64'(write_en), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_we", 64'(write_en), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_rd", 64'(read_address), 64'd0);
    check("abort_wr", 64'(write_address), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_we", 64'(write_en), 64'd0);
    end
    rst = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      check("post_abort_we", 64'(write_en), 64'd0);
      check("post_abort_done", 64'(done), 64'd0);
      check("post_abort_rd", 64'(read_address), 64'd0);
    end

    run_and_check("after_abort", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
